fp_mat_stream: RTL and testbench

//   Streaming front/back end for the combinational fixed-point matrix multiplier.

---
 rtl/fp_mat_stream.sv | 113 +++++++++++
 tb/tb_fp_mat_stream.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mat_stream.sv
// Streaming load/capture/send wrapper around a combinational fixed-point matrix multiplier.
// A then B are loaded row-major, held on flat buses, and the product C is streamed back row-major.
module fp_mat_stream #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned RESULT_WIDTH = 16,
  parameter int unsigned ROW_1        = 4,
  parameter int unsigned COL_1        = 4,
  parameter int unsigned COL_2        = 4,
  parameter int unsigned CALC_CYCLES  = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [DATA_WIDTH-1:0]               s_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [RESULT_WIDTH-1:0]             m_data,
  output logic                                m_last,
  output logic                                busy,
  output logic [DATA_WIDTH*ROW_1*COL_1-1:0]   mat_a,
  output logic [DATA_WIDTH*COL_1*COL_2-1:0]   mat_b,
  input  logic [RESULT_WIDTH*ROW_1*COL_2-1:0] mat_c
);

  localparam int unsigned A_N    = ROW_1 * COL_1;
  localparam int unsigned B_N    = COL_1 * COL_2;
  localparam int unsigned C_N    = ROW_1 * COL_2;
  localparam int unsigned AB_MAX = (A_N > B_N) ? A_N : B_N;
  localparam int unsigned MAX_N  = (AB_MAX > C_N) ? AB_MAX : C_N;
  localparam int unsigned IDX_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int unsigned WAIT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, CALC, SEND} state_e;

  state_e                          state_q;
  logic [IDX_W-1:0]                idx_q;
  logic [WAIT_W-1:0]               wait_q;
  logic [DATA_WIDTH*A_N-1:0]       a_q;
  logic [DATA_WIDTH*B_N-1:0]       b_q;
  logic [RESULT_WIDTH*C_N-1:0]     c_q;
  logic                            s_hs;
  logic                            m_hs;

  // Every output is a decode of registered state; s_ready is additionally held low during rst.
  assign s_ready = !rst && ((state_q == LOAD_A) || (state_q == LOAD_B));
  assign m_valid = (state_q == SEND);
  assign busy    = (state_q != LOAD_A);
  assign m_last  = m_valid && (idx_q == IDX_W'(C_N - 1));
  assign m_data  = m_valid ? c_q[RESULT_WIDTH*idx_q +: RESULT_WIDTH] : '0;
  assign mat_a   = a_q;
  assign mat_b   = b_q;
  assign s_hs    = s_valid && s_ready;
  assign m_hs    = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      wait_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (s_hs) begin
            a_q[DATA_WIDTH*idx_q +: DATA_WIDTH] <= s_data;
            if (idx_q == IDX_W'(A_N - 1)) begin
              idx_q   <= '0;
              state_q <= LOAD_B;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (s_hs) begin
            b_q[DATA_WIDTH*idx_q +: DATA_WIDTH] <= s_data;
            if (idx_q == IDX_W'(B_N - 1)) begin
              idx_q   <= '0;
              wait_q  <= '0;
              state_q <= CALC;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        CALC: begin
          // Multiplier is combinational on the A/B registers; sample once it has settled.
          if (wait_q == WAIT_W'(CALC_CYCLES - 1)) begin
            c_q     <= mat_c;
            state_q <= SEND;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        SEND: begin
          if (m_hs) begin
            if (idx_q == IDX_W'(C_N - 1)) begin
              idx_q   <= '0;
              state_q <= LOAD_A;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mat_stream.sv
// Bench for fp_mat_stream with a behavioural Q8.8 multiplier on the flat buses and a real-valued reference.
module tb_fp_mat_stream;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned CC = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [DW-1:0]      s_data;
  logic               m_valid;
  logic               m_ready;
  logic [RW-1:0]      m_data;
  logic               m_last;
  logic               busy;
  logic [DW*16-1:0]   mat_a;
  logic [DW*16-1:0]   mat_b;
  logic [RW*16-1:0]   mat_c;

  logic [15:0]        a_m [16];
  logic [15:0]        b_m [16];
  logic [15:0]        e_m [16];
  logic [255:0]       fa;
  logic [255:0]       fb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_mat_stream #(
    .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .ROW_1(N), .COL_1(N), .COL_2(N), .CALC_CYCLES(CC)
  ) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy),
    .mat_a(mat_a), .mat_b(mat_b), .mat_c(mat_c)
  );

  // External multiplier: C = (A*B) >> 8 with Q8.8 wrap-around.
  always_comb begin
    longint acc;
    mat_c = '0;
    acc   = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) begin
          acc = acc + longint'($signed(mat_a[DW*(i*4+k) +: DW])) *
                      longint'($signed(mat_b[DW*(k*4+j) +: DW]));
        end
        mat_c[RW*(i*4+j) +: RW] = RW'(acc >>> 8);
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void flatten();
    for (int i = 0; i < 16; i++) begin
      fa[16*i +: 16] = a_m[i];
      fb[16*i +: 16] = b_m[i];
    end
  endfunction

  // Reference in real-number terms: sum of products of Q8.8 values, floored back to Q8.8.
  function automatic void model();
    real s;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0.0;
        for (int k = 0; k < 4; k++) begin
          s = s + (real'($signed(a_m[i*4+k])) / 256.0) * (real'($signed(b_m[k*4+j])) / 256.0);
        end
        e_m[i*4+j] = 16'($rtoi($floor(s * 256.0)));
      end
    end
  endfunction

  function automatic void set_identity();
    for (int k = 0; k < 16; k++) begin
      a_m[k] = ((k / 4) == (k % 4)) ? 16'h0100 : 16'h0000;
      b_m[k] = 16'(k << 8);
      e_m[k] = 16'(k << 8);
    end
    flatten();
  endfunction

  function automatic void set_scale();
    for (int k = 0; k < 16; k++) begin
      a_m[k] = 16'h0200;
      b_m[k] = 16'h0080;
      e_m[k] = 16'h0400;
    end
    flatten();
  endfunction

  function automatic void set_random();
    for (int k = 0; k < 16; k++) begin
      a_m[k] = 16'($urandom);
      b_m[k] = 16'($urandom);
    end
    model();
    flatten();
  endfunction

  task automatic send_beat(input logic [15:0] d, input bit gaps, output int waited);
    int g;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 16'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    #1;
    waited = 0;
    while (!s_ready) begin
      waited++;
      if (waited > 50) begin
        check("s_ready_timeout", 256'(s_ready), 256'(1));
        break;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
  endtask

  task automatic load_set(input bit gaps, input bit expect_immediate, input int b_beats);
    int waited;
    for (int i = 0; i < 16 + b_beats; i++) begin
      send_beat((i < 16) ? a_m[i] : b_m[i-16], gaps, waited);
      if (i == 0 && expect_immediate) check("b2b_first_accept_wait", 256'(waited), 256'(0));
    end
  endtask

  // mode 0: always ready; 1: 5-cycle stall at beat 3 then random; 2: random ready.
  task automatic collect(input int mode, input bit hold_sv);
    int          beat   = 0;
    int          n      = 0;
    int          first  = -1;
    int          stall  = 0;
    bit          done   = 0;
    bit          stalled = 0;
    logic [15:0] prev_d = '0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      s_valid = hold_sv;
      s_data  = 16'($urandom);
      case (mode)
        0: m_ready = 1'b1;
        1: begin
          if (beat == 3 && stall < 5) begin
            m_ready = 1'b0;
            stall++;
          end else begin
            m_ready = (beat > 3) ? 1'($urandom_range(0, 1)) : 1'b1;
          end
        end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (hold_sv) check("s_ready_low_while_busy", 256'(s_ready), 256'(0));
      if (m_valid) begin
        if (first < 0) begin
          first = n;
          check("latency", 256'(n), 256'(CC + 1));
          check("mat_a_hold", mat_a, fa);
          check("mat_b_hold", mat_b, fb);
        end
        if (stalled) check("stall_hold", 256'(m_data), 256'(prev_d));
        if (beat >= 16) begin
          check("extra_beat", 256'(beat), 256'(15));
          done = 1;
        end else begin
          check($sformatf("m_data[%0d]", beat), 256'(m_data), 256'(e_m[beat]));
          check($sformatf("m_last[%0d]", beat), 256'(m_last), 256'(beat == 15));
          stalled = !m_ready;
          prev_d  = m_data;
          if (m_ready) begin
            beat++;
            if (m_last) begin
              @(posedge clk);
              done = 1;
            end
          end
        end
      end else if (first >= 0) begin
        check("m_valid_dropped", 256'(m_valid), 256'(1));
        done = 1;
      end
    end
    check("beat_count", 256'(beat), 256'(16));
  endtask

  task automatic post_idle();
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check("post_m_valid", 256'(m_valid), 256'(0));
    check("post_busy", 256'(busy), 256'(0));
    check("post_s_ready", 256'(s_ready), 256'(1));
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_s_ready", 256'(s_ready), 256'(0));
    check("rst_m_valid", 256'(m_valid), 256'(0));
    check("rst_m_data", 256'(m_data), 256'(0));
    check("rst_m_last", 256'(m_last), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_mat_a", mat_a, 256'(0));
    check("rst_mat_b", mat_b, 256'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_s_ready", 256'(s_ready), 256'(1));

    // Identity times ramp
    set_identity();
    load_set(0, 0, 16);
    collect(0, 0);
    post_idle();

    // Uniform 2.0 x 0.5
    set_scale();
    load_set(0, 0, 16);
    collect(0, 0);
    post_idle();

    // Identity with stall at beat 3
    set_identity();
    load_set(0, 0, 16);
    collect(1, 0);
    post_idle();

    // Input gaps, s_valid held high while busy
    set_scale();
    load_set(1, 0, 16);
    collect(2, 1);
    post_idle();

    // Reset in the middle of B
    set_random();
    load_set(0, 0, 7);
    @(negedge clk);
    s_valid = 1'b0;
    rst     = 1'b1;
    #1;
    check("midrst_s_ready", 256'(s_ready), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_mat_a", mat_a, 256'(0));
    check("midrst_mat_b", mat_b, 256'(0));
    check("midrst_m_valid", 256'(m_valid), 256'(0));
    set_identity();
    load_set(0, 0, 16);
    collect(0, 0);
    post_idle();

    // Back-to-back sets
    set_identity();
    load_set(0, 0, 16);
    collect(0, 0);
    set_scale();
    load_set(0, 1, 16);
    collect(0, 0);
    post_idle();

    // Random operands and handshakes
    for (int t = 0; t < 4; t++) begin
      set_random();
      load_set(1, 0, 16);
      collect(2, t[0]);
      post_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
